// File: rtl/tcam_pkg.sv
// ---------------------------------------------------------------------------
// tcam_pkg
// Shared definitions for the TCAM routing memory.
//   mode_t  : 3-bit command decoded by tcam_mem every cycle
//   MODE_I  : idle (also used for the undefined encodings 110/111)
//   MODE_W  : write one plane / valid bit of an entry
//   MODE_R  : read one plane / valid bit of an entry
//   MODE_F  : fire lookup keyed by the source packet ID
//   MODE_C  : masked compare against the full entry width
//   MODE_RST: flush, clears every valid bit but keeps the planes
// ---------------------------------------------------------------------------
package tcam_pkg;

   typedef enum logic [2:0] {
      MODE_I   = 3'b000,
      MODE_W   = 3'b001,
      MODE_R   = 3'b010,
      MODE_F   = 3'b011,
      MODE_C   = 3'b100,
      MODE_RST = 3'b101
   } mode_t;

endpackage

// File: rtl/tcam_match_line.sv
// ---------------------------------------------------------------------------
// tcam_match_line
// Ternary compare for a single TCAM entry.
//   key     : search key (compare data or {PacketID, zeros} on fire)
//   mask    : key mask, 1 = bit takes part in the search
//   data    : stored data plane of the entry
//   care    : stored care plane, 1 = bit is compared, 0 = don't care
//   valid   : entry valid bit
//   bank_en : compare enable of the bank this entry belongs to
//   match   : 1 when the entry hits
// ---------------------------------------------------------------------------
module tcam_match_line #(
   parameter int Bits = 8
) (
   input  logic [Bits-1:0] key,
   input  logic [Bits-1:0] mask,
   input  logic [Bits-1:0] data,
   input  logic [Bits-1:0] care,
   input  logic            valid,
   input  logic            bank_en,
   output logic            match
);

   // A bit can only cause a miss when both the entry and the search care
   // about it and the stored value differs from the key.
   logic [Bits-1:0] mismatch_bits;

   assign mismatch_bits = care & mask & (data ^ key);
   assign match         = valid & bank_en & ~(|mismatch_bits);

endmodule

// File: rtl/tcam_mem.sv
// ---------------------------------------------------------------------------
// tcam_mem
// Ternary CAM routing memory for the spiking-neuron packet fabric.
//   clk, rst     : clock and synchronous active-high reset
//   MODE         : command (idle/write/read/fire/compare/flush)
//   PacketID_In  : source ID used as key on fire
//   Data_In      : write data / compare key
//   Mskb_In      : write-bit enable on write, key mask on compare
//   A_In         : entry address for write/read
//   Dcs_In       : plane select, 1 = data plane, 0 = care plane
//   Vbe_In, Vbi_In : valid-bit access enable and valid bit to write
//   Cbe_In       : per-bank compare enable
//   DstID_Out    : destination ID of the lowest-index hit
//   Data_Out, Vbo_Out : read data and read valid bit
//   Hit_Out, HitLine_Out : any-hit flag and per-entry match vector
// Entry layout: data[Bits-1 -: ID_Width] = source ID,
//               data[ID_Width-1:0]       = destination ID.
// ---------------------------------------------------------------------------
module tcam_mem
   import tcam_pkg::*;
#(
   parameter int ID_Width    = 4,
   parameter int AddressSize = 4,
   parameter int Bits        = 8,
   parameter int Words       = 16,
   parameter int BankSize    = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2:0]             MODE,
   input  logic [ID_Width-1:0]    PacketID_In,
   input  logic [Bits-1:0]        Data_In,
   input  logic [Bits-1:0]        Mskb_In,
   input  logic [AddressSize-1:0] A_In,
   input  logic                   Dcs_In,
   input  logic                   Vbe_In,
   input  logic                   Vbi_In,
   input  logic [BankSize-1:0]    Cbe_In,
   output logic [ID_Width-1:0]    DstID_Out,
   output logic [Bits-1:0]        Data_Out,
   output logic                   Vbo_Out,
   output logic                   Hit_Out,
   output logic [Words-1:0]       HitLine_Out
);

   localparam int EntriesPerBank = Words / BankSize;

   mode_t mode;

   logic [Bits-1:0]     data_mem [Words];
   logic [Bits-1:0]     care_mem [Words];
   logic [Words-1:0]    valid_mem;

   logic [Bits-1:0]     search_key;
   logic [Bits-1:0]     search_mask;
   logic                fire_cmd;
   logic [Words-1:0]    hit_line;
   logic [ID_Width-1:0] dst_next;

   assign mode     = mode_t'(MODE);
   assign fire_cmd = (mode == MODE_F);

   // Fire searches only on the source-ID field, so the low bits of both
   // key and mask are forced to zero and every bank is enabled.
   always_comb begin
      search_key  = Data_In;
      search_mask = Mskb_In;
      if (fire_cmd) begin
         search_key  = {PacketID_In, {(Bits-ID_Width){1'b0}}};
         search_mask = {{ID_Width{1'b1}}, {(Bits-ID_Width){1'b0}}};
      end
   end

   // One ternary compare per entry; the bank an entry belongs to is fixed
   // by its address, so the bank enable is selected at elaboration.
   for (genvar e = 0; e < Words; e++) begin : g_line
      localparam int Bank = e / EntriesPerBank;
      logic bank_en;

      assign bank_en = fire_cmd | Cbe_In[Bank];

      tcam_match_line #(
         .Bits (Bits)
      ) u_line (
         .key     (search_key),
         .mask    (search_mask),
         .data    (data_mem[e]),
         .care    (care_mem[e]),
         .valid   (valid_mem[e]),
         .bank_en (bank_en),
         .match   (hit_line[e])
      );
   end

   // Priority encoder: scanning from the top down lets the lowest-index hit
   // overwrite any higher one, so it wins.
   always_comb begin
      dst_next = '0;
      for (int e = Words - 1; e >= 0; e--) begin
         if (hit_line[e]) begin
            dst_next = data_mem[e][ID_Width-1:0];
         end
      end
   end

   // Storage and output registers. Results of read/compare/fire hold until
   // the next command of the same class, so each command updates only its
   // own outputs. Reset wins over any command in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int e = 0; e < Words; e++) begin
            data_mem[e] <= '0;
            care_mem[e] <= '0;
         end
         valid_mem   <= '0;
         DstID_Out   <= '0;
         Data_Out    <= '0;
         Vbo_Out     <= 1'b0;
         Hit_Out     <= 1'b0;
         HitLine_Out <= '0;
      end else begin
         case (mode)
            MODE_W: begin
               if (Dcs_In) begin
                  data_mem[A_In] <= (data_mem[A_In] & ~Mskb_In) | (Data_In & Mskb_In);
               end else begin
                  care_mem[A_In] <= (care_mem[A_In] & ~Mskb_In) | (Data_In & Mskb_In);
               end
               if (Vbe_In) begin
                  valid_mem[A_In] <= Vbi_In;
               end
            end
            MODE_R: begin
               Data_Out <= Dcs_In ? data_mem[A_In] : care_mem[A_In];
               Vbo_Out  <= Vbe_In ? valid_mem[A_In] : 1'b0;
            end
            MODE_F, MODE_C: begin
               HitLine_Out <= hit_line;
               Hit_Out     <= |hit_line;
               DstID_Out   <= dst_next;
            end
            MODE_RST: begin
               valid_mem <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tcam_mem.sv
// ---------------------------------------------------------------------------
// tb_tcam_mem
// Scoreboard bench for tcam_mem. Stimulus tasks push the hand-computed
// result of every read/compare/fire into a queue; a monitor pops and checks
// it in the cycle the DUT presents the registered result.
// ---------------------------------------------------------------------------
module tb_tcam_mem;
   import tcam_pkg::*;

   localparam int ID_Width    = 4;
   localparam int AddressSize = 4;
   localparam int Bits        = 8;
   localparam int Words       = 16;
   localparam int BankSize    = 1;

   localparam logic [1:0] KIND_READ = 2'd0;
   localparam logic [1:0] KIND_HIT  = 2'd1;
   localparam logic [1:0] KIND_ALL  = 2'd2;

   typedef struct {
      logic [1:0]          kind;
      string               name;
      logic [Bits-1:0]     data;
      logic                vbo;
      logic                hit;
      logic [Words-1:0]    hitline;
      logic [ID_Width-1:0] dst;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [2:0]             MODE = 3'b000;
   logic [ID_Width-1:0]    PacketID_In = '0;
   logic [Bits-1:0]        Data_In = '0;
   logic [Bits-1:0]        Mskb_In = '0;
   logic [AddressSize-1:0] A_In = '0;
   logic                   Dcs_In = 1'b0;
   logic                   Vbe_In = 1'b0;
   logic                   Vbi_In = 1'b0;
   logic [BankSize-1:0]    Cbe_In = '0;
   logic [ID_Width-1:0]    DstID_Out;
   logic [Bits-1:0]        Data_Out;
   logic                   Vbo_Out;
   logic                   Hit_Out;
   logic [Words-1:0]       HitLine_Out;

   exp_t exp_q[$];
   logic resp_due = 1'b0;
   int   total_checks = 0;
   int   bad_checks = 0;

   tcam_mem #(
      .ID_Width    (ID_Width),
      .AddressSize (AddressSize),
      .Bits        (Bits),
      .Words       (Words),
      .BankSize    (BankSize)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .MODE        (MODE),
      .PacketID_In (PacketID_In),
      .Data_In     (Data_In),
      .Mskb_In     (Mskb_In),
      .A_In        (A_In),
      .Dcs_In      (Dcs_In),
      .Vbe_In      (Vbe_In),
      .Vbi_In      (Vbi_In),
      .Cbe_In      (Cbe_In),
      .DstID_Out   (DstID_Out),
      .Data_Out    (Data_Out),
      .Vbo_Out     (Vbo_Out),
      .Hit_Out     (Hit_Out),
      .HitLine_Out (HitLine_Out)
   );

   always #5 clk = ~clk;

   // Drive one command, applied just after a rising edge so the DUT samples
   // it on the following edge.
   task automatic applyStimulus(input logic do_rst, input logic [2:0] mode,
                                input logic [AddressSize-1:0] a,
                                input logic [Bits-1:0] data,
                                input logic [Bits-1:0] mskb,
                                input logic dcs, input logic vbe,
                                input logic vbi, input logic [BankSize-1:0] cbe,
                                input logic [ID_Width-1:0] pid);
      @(posedge clk);
      #1;
      rst         = do_rst;
      MODE        = mode;
      A_In        = a;
      Data_In     = data;
      Mskb_In     = mskb;
      Dcs_In      = dcs;
      Vbe_In      = vbe;
      Vbi_In      = vbi;
      Cbe_In      = cbe;
      PacketID_In = pid;
   endtask

   task automatic push_exp(input logic [1:0] kind, input string name,
                           input logic [Bits-1:0] data, input logic vbo,
                           input logic hit, input logic [Words-1:0] hitline,
                           input logic [ID_Width-1:0] dst);
      exp_t e;
      e.kind = kind;  e.name = name;  e.data = data;  e.vbo = vbo;
      e.hit = hit;    e.hitline = hitline;  e.dst = dst;
      exp_q.push_back(e);
   endtask

   task automatic do_write(input logic do_rst, input logic [AddressSize-1:0] a,
                           input logic [Bits-1:0] data, input logic [Bits-1:0] mskb,
                           input logic dcs, input logic vbe, input logic vbi);
      applyStimulus(do_rst, MODE_W, a, data, mskb, dcs, vbe, vbi, '0, '0);
   endtask

   task automatic do_read(input string name, input logic [AddressSize-1:0] a,
                          input logic dcs, input logic vbe,
                          input logic [Bits-1:0] exp_data, input logic exp_vbo,
                          input logic all);
      push_exp(all ? KIND_ALL : KIND_READ, name, exp_data, exp_vbo, 1'b0, '0, '0);
      applyStimulus(1'b0, MODE_R, a, '0, '0, dcs, vbe, 1'b0, '0, '0);
   endtask

   task automatic do_cmp(input string name, input logic [Bits-1:0] key,
                         input logic [Bits-1:0] mskb, input logic [BankSize-1:0] cbe,
                         input logic exp_hit, input logic [Words-1:0] exp_line,
                         input logic [ID_Width-1:0] exp_dst);
      push_exp(KIND_HIT, name, '0, 1'b0, exp_hit, exp_line, exp_dst);
      applyStimulus(1'b0, MODE_C, '0, key, mskb, 1'b0, 1'b0, 1'b0, cbe, '0);
   endtask

   task automatic do_fire(input string name, input logic [ID_Width-1:0] pid,
                          input logic exp_hit, input logic [Words-1:0] exp_line,
                          input logic [ID_Width-1:0] exp_dst);
      push_exp(KIND_HIT, name, '0, 1'b0, exp_hit, exp_line, exp_dst);
      applyStimulus(1'b0, MODE_F, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, pid);
   endtask

   task automatic cmp_val(input string name, input logic [31:0] got,
                          input logic [31:0] want);
      total_checks++;
      if (got !== want) begin
         bad_checks++;
         $display("[TB] FAIL %s got=0x%0h want=0x%0h", name, got, want);
      end
   endtask

   // Pop the oldest expectation and compare it with the DUT outputs.
   task automatic checkOutput();
      exp_t e;
      if (exp_q.size() == 0) begin
         total_checks++;
         bad_checks++;
         $display("[TB] FAIL scoreboard_empty got=1 want=0");
         return;
      end
      e = exp_q.pop_front();
      if (e.kind == KIND_READ || e.kind == KIND_ALL) begin
         cmp_val({e.name, ".data"}, 32'(Data_Out), 32'(e.data));
         cmp_val({e.name, ".vbo"}, 32'(Vbo_Out), 32'(e.vbo));
      end
      if (e.kind == KIND_HIT || e.kind == KIND_ALL) begin
         cmp_val({e.name, ".hit"}, 32'(Hit_Out), 32'(e.hit));
         cmp_val({e.name, ".hitline"}, 32'(HitLine_Out), 32'(e.hitline));
         cmp_val({e.name, ".dst"}, 32'(DstID_Out), 32'(e.dst));
      end
   endtask

   // Monitor: a result command sampled on a rising edge is visible on the
   // following falling edge.
   always @(posedge clk) begin
      resp_due <= !rst && (MODE == MODE_R || MODE == MODE_C || MODE == MODE_F);
   end

   always @(negedge clk) begin
      if (resp_due) begin
         checkOutput();
      end
   end

   initial begin
      int wait_cycles;

      // Reset for two cycles, then a read must see all-zero state.
      applyStimulus(1'b1, MODE_I, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, MODE_I, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      do_read("reset_read", 4'd1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);

      // Write/read including a partial bit-masked write.
      do_write(1'b0, 4'd1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1);
      do_read("wr_rd_full", 4'd1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
      do_write(1'b0, 4'd1, 8'hA5, 8'h0F, 1'b1, 1'b0, 1'b0);
      do_read("wr_rd_masked", 4'd1, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0);
      do_read("rd_care_novbe", 4'd1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Flush drops entry 1 (care=0 would otherwise match everything).
      applyStimulus(1'b0, MODE_RST, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      do_write(1'b0, 4'd3, 8'h5C, 8'hFF, 1'b1, 1'b1, 1'b1);
      do_write(1'b0, 4'd3, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0);
      do_cmp("cmp_hit", 8'h57, 8'hFF, 1'b1, 1'b1, 16'h0008, 4'hC);
      do_cmp("cmp_miss", 8'h67, 8'hFF, 1'b1, 1'b0, 16'h0000, 4'h0);
      do_cmp("cmp_keymask", 8'h67, 8'h0F, 1'b1, 1'b1, 16'h0008, 4'hC);
      do_cmp("cmp_bank_off", 8'h57, 8'hFF, 1'b0, 1'b0, 16'h0000, 4'h0);

      // Fire priority: entries 2 and 5 share source ID 3.
      do_write(1'b0, 4'd2, 8'h39, 8'hFF, 1'b1, 1'b1, 1'b1);
      do_write(1'b0, 4'd2, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0);
      do_write(1'b0, 4'd5, 8'h34, 8'hFF, 1'b1, 1'b1, 1'b1);
      do_write(1'b0, 4'd5, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0);
      do_fire("fire_prio", 4'h3, 1'b1, 16'h0024, 4'h9);
      do_fire("fire_src5", 4'h5, 1'b1, 16'h0008, 4'hC);
      do_fire("fire_miss", 4'h7, 1'b0, 16'h0000, 4'h0);

      // Flush keeps planes but clears valid bits.
      applyStimulus(1'b0, MODE_RST, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      do_fire("flush_fire", 4'h3, 1'b0, 16'h0000, 4'h0);
      do_read("flush_read", 4'd2, 1'b1, 1'b1, 8'h39, 1'b0, 1'b0);

      // Reset in the same cycle as a write: nothing may be stored.
      do_write(1'b1, 4'd7, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
      do_read("rst_mid_write", 4'd7, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
      do_read("rst_clears_e2", 4'd2, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);

      applyStimulus(1'b0, MODE_I, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);

      wait_cycles = 0;
      while (exp_q.size() != 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (exp_q.size() != 0) begin
         total_checks++;
         bad_checks++;
         $display("[TB] FAIL drain got=%0d want=0", exp_q.size());
      end
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
